// File: rtl/ram_tdp_csoe_be.sv
// True dual-port synchronous RAM with per-port chip-select/output-enable,
// byte-lane write enables, selectable same-port read-during-write behaviour,
// optional output register stage and a registered write-collision flag.
//
// Read-data handshake: dvalid_x is a one-cycle strobe that qualifies dout_x
// in the same cycle. There is no ready/backpressure. When dvalid_x is low,
// dout_x holds the last value delivered.
module ram_tdp_csoe_be #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 6,
  parameter int RDEPTH  = 1 << AWIDTH,
  parameter int NBYTE   = DWIDTH / 8,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_0,
  input  logic              oe_0,
  input  logic              we_0,
  input  logic [NBYTE-1:0]  be_0,
  input  logic [AWIDTH-1:0] addr_0,
  input  logic [DWIDTH-1:0] din_0,
  output logic [DWIDTH-1:0] dout_0,
  output logic              dvalid_0,
  input  logic              cs_1,
  input  logic              oe_1,
  input  logic              we_1,
  input  logic [NBYTE-1:0]  be_1,
  input  logic [AWIDTH-1:0] addr_1,
  input  logic [DWIDTH-1:0] din_1,
  output logic [DWIDTH-1:0] dout_1,
  output logic              dvalid_1,
  output logic              coll_err
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(RDEPTH);

  logic [DWIDTH-1:0] mem [RDEPTH];

  // Per-port views so both ports share one description.
  logic              cs   [2];
  logic              oe   [2];
  logic              we   [2];
  logic [NBYTE-1:0]  be   [2];
  logic [AWIDTH-1:0] addr [2];
  logic [DWIDTH-1:0] din  [2];

  assign cs[0]   = cs_0;   assign cs[1]   = cs_1;
  assign oe[0]   = oe_0;   assign oe[1]   = oe_1;
  assign we[0]   = we_0;   assign we[1]   = we_1;
  assign be[0]   = be_0;   assign be[1]   = be_1;
  assign addr[0] = addr_0; assign addr[1] = addr_1;
  assign din[0]  = din_0;  assign din[1]  = din_1;

  logic              in_rng [2];
  logic              wr     [2];
  logic              rd     [2];
  logic [DWIDTH-1:0] rdata  [2];

  // Qualified strobes and the word each port would read this cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = ({1'b0, addr[p]} < DEPTH_W);
      wr[p]     = cs[p] & we[p] & (|be[p]) & in_rng[p] & ~rst;
      rd[p]     = cs[p] & oe[p] & ~rst & ~((RD_MODE == 2) & wr[p]);
      // mem is sampled before this edge's writes, so cross-port reads are
      // always read-first; only same-port WRITE_FIRST merges its own data.
      rdata[p]  = in_rng[p] ? mem[addr[p]] : '0;
      if ((RD_MODE == 1) && wr[p]) begin
        for (int i = 0; i < NBYTE; i++) begin
          if (be[p][i]) rdata[p][i*8 +: 8] = din[p][i*8 +: 8];
        end
      end
    end
  end

  // Byte-lane writes; port 0 is applied last so it wins shared lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTE; i++) begin
      if (wr[1] && be[1][i]) mem[addr[1]][i*8 +: 8] <= din[1][i*8 +: 8];
      if (wr[0] && be[0][i]) mem[addr[0]][i*8 +: 8] <= din[0][i*8 +: 8];
    end
  end

  logic [DWIDTH-1:0] s1_data  [2];
  logic              s1_valid [2];

  // First read stage: capture data on a read, otherwise hold.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        s1_data[p]  <= '0;
        s1_valid[p] <= 1'b0;
      end else begin
        s1_valid[p] <= rd[p];
        if (rd[p]) s1_data[p] <= rdata[p];
      end
    end
  end

  logic [DWIDTH-1:0] q_data  [2];
  logic              q_valid [2];

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DWIDTH-1:0] s2_data  [2];
      logic              s2_valid [2];

      // Optional second stage; reset drops anything still in flight.
      always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
          if (rst) begin
            s2_data[p]  <= '0;
            s2_valid[p] <= 1'b0;
          end else begin
            s2_valid[p] <= s1_valid[p];
            if (s1_valid[p]) s2_data[p] <= s1_data[p];
          end
        end
      end

      assign q_data[0]  = s2_data[0];
      assign q_data[1]  = s2_data[1];
      assign q_valid[0] = s2_valid[0];
      assign q_valid[1] = s2_valid[1];
    end else begin : g_no_out_reg
      assign q_data[0]  = s1_data[0];
      assign q_data[1]  = s1_data[1];
      assign q_valid[0] = s1_valid[0];
      assign q_valid[1] = s1_valid[1];
    end
  endgenerate

  assign dout_0   = q_data[0];
  assign dout_1   = q_data[1];
  assign dvalid_0 = q_valid[0];
  assign dvalid_1 = q_valid[1];

  // Flag a same-address dual write that overlaps on at least one lane.
  always_ff @(posedge clk) begin
    if (rst) coll_err <= 1'b0;
    else     coll_err <= wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));
  end

endmodule
